inst_encoder: RTL



---
 rtl/inst_encoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I field-to-word assembler: validates and packs instruction fields,
// then queues the encoded words in a small output FIFO.
module inst_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [6:0]                      in_opcode,
  input  logic [4:0]                      in_rd,
  input  logic [4:0]                      in_rs,
  input  logic [4:0]                      in_rs2,
  input  logic [2:0]                      in_funct3,
  input  logic [6:0]                      in_funct7,
  input  logic [31:0]                     in_imm,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_inst,
  output logic                            err_pulse,
  output logic [ERR_W-1:0]                err_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

  fmt_e        fmt;
  logic        is_shift;
  logic        fits12, fits13, fits21;
  logic [31:0] enc_word;
  logic        enc_err;

  // An immediate fits N signed bits when every bit above bit N-1 equals the sign bit.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign is_shift = (in_opcode == OPC_OP_IMM) &&
                    ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  always_comb begin
    fmt = FMT_BAD;
    unique case (in_opcode)
      OPC_LUI, OPC_AUIPC:                               fmt = FMT_U;
      OPC_OP:                                           fmt = FMT_R;
      OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_MISC_MEM,
      OPC_SYSTEM:                                       fmt = FMT_I;
      OPC_JAL:                                          fmt = FMT_J;
      OPC_BRANCH:                                       fmt = FMT_B;
      OPC_STORE:                                        fmt = FMT_S;
      default:                                          fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    enc_word = '0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        if (is_shift) begin
          enc_word = {in_funct7, in_imm[4:0], in_rs, in_funct3, in_rd, in_opcode};
          enc_err  = |in_imm[31:5];
        end else begin
          enc_word = {in_imm[11:0], in_rs, in_funct3, in_rd, in_opcode};
          enc_err  = ~fits12;
        end
      end
      FMT_S: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~fits12;
      end
      FMT_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = ~fits13 | in_imm[0];
      end
      FMT_U: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      FMT_J: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~fits21 | in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  logic             s1_valid, s1_err, s1_retire;
  logic [31:0]      s1_word;
  logic             accept, push, pop, full;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign s1_retire = s1_valid & (s1_err | ~full | pop);
  assign in_ready  = ~s1_valid | s1_retire;
  assign accept    = in_valid & in_ready;
  assign push      = s1_valid & ~s1_err & (~full | pop);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_word  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_err   <= enc_err;
      s1_word  <= enc_word;
    end else if (s1_retire) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= s1_valid & s1_err;
      if (s1_valid && s1_err && !(&err_count))
        err_count <= err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is cleared on reset because out_inst reads the head
      // entry directly and must show zero after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s1_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign out_valid  = (count != '0);
  assign out_inst   = mem[rd_ptr];
  assign fifo_count = count;

endmodule
